// File: rtl/stepper_stroke_driver.sv
// Stepper stroke engine: drives a forward leg of N steps, an optional dwell, then a retract leg.
// Steps land every `period` cycles; done_o/aborted_o pulse one cycle at stroke end; no backpressure.
module stepper_stroke_driver #(
   parameter int CNT_W   = 16,
   parameter int PER_W   = 20,
   parameter int DWELL   = 100,
   parameter int HOLD_EN = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             dir_i,
   input  logic             half_i,
   input  logic             return_i,
   input  logic [CNT_W-1:0] steps_i,
   input  logic [PER_W-1:0] period_i,
   input  logic             abort_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             aborted_o,
   output logic [CNT_W-1:0] leg_cnt_o,
   output logic [3:0]       signal_o
);

   localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

   typedef enum logic [2:0] {S_IDLE, S_FWD, S_DWELL, S_RET, S_DONE} state_t;

   state_t           state, state_nxt;
   logic             armed, coil_en, dir_q, half_q, ret_q, aborted_q;
   logic [CNT_W-1:0] steps_q, leg_cnt;
   logic [PER_W-1:0] period_q, per_cnt;
   logic [DW_W-1:0]  dwell_cnt;
   logic [2:0]       index, stride;
   logic [3:0]       pattern;
   logic             accept, moving, busy, leg_end, step_go, dwell_end;

   assign accept    = (state == S_IDLE) && start_i && armed;
   assign moving    = (state == S_FWD) || (state == S_RET);
   assign busy      = moving || (state == S_DWELL);
   // A leg finishes on the cycle after its last step, so a zero-step stroke
   // passes through FWD for one cycle without moving.
   assign leg_end   = moving && (leg_cnt == steps_q);
   assign step_go   = moving && !abort_i && !leg_end && (per_cnt == period_q - PER_W'(1));
   assign dwell_end = (state == S_DWELL) && !abort_i && (dwell_cnt == DW_W'(DWELL - 1));
   // Full-step from an odd index first lands on the adjacent even index.
   assign stride    = (half_q || index[0]) ? 3'd1 : 3'd2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_FWD;
         S_FWD: begin
            if (abort_i)      state_nxt = S_DONE;
            else if (leg_end) state_nxt = (ret_q && (steps_q != '0)) ? S_DWELL : S_DONE;
         end
         S_DWELL: begin
            if (abort_i)        state_nxt = S_DONE;
            else if (dwell_end) state_nxt = S_RET;
         end
         S_RET:   if (abort_i || leg_end) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed     <= 1'b0;
         coil_en   <= 1'b0;
         dir_q     <= 1'b0;
         half_q    <= 1'b0;
         ret_q     <= 1'b0;
         aborted_q <= 1'b0;
         steps_q   <= '0;
         period_q  <= PER_W'(2);
         leg_cnt   <= '0;
         per_cnt   <= '0;
         dwell_cnt <= '0;
         index     <= 3'd0;
      end else begin
         if (accept)        armed <= 1'b0;
         else if (!start_i) armed <= 1'b1;

         per_cnt   <= (!moving || step_go) ? '0 : per_cnt + PER_W'(1);
         dwell_cnt <= (state == S_DWELL) ? dwell_cnt + DW_W'(1) : '0;

         if (accept) begin
            coil_en   <= 1'b1;
            dir_q     <= dir_i;
            half_q    <= half_i;
            ret_q     <= return_i;
            steps_q   <= steps_i;
            period_q  <= (period_i < PER_W'(2)) ? PER_W'(2) : period_i;
            leg_cnt   <= '0;
            aborted_q <= 1'b0;
         end else begin
            if (busy && abort_i) aborted_q <= 1'b1;
            if (step_go) begin
               leg_cnt <= leg_cnt + CNT_W'(1);
               index   <= dir_q ? index + stride : index - stride;
            end
            if (dwell_end) begin
               leg_cnt <= '0;
               dir_q   <= ~dir_q;
            end
         end
      end
   end

   always_comb begin
      pattern = 4'b0000;
      case (index)
         3'd0: pattern = 4'b1000;
         3'd1: pattern = 4'b1100;
         3'd2: pattern = 4'b0100;
         3'd3: pattern = 4'b0110;
         3'd4: pattern = 4'b0010;
         3'd5: pattern = 4'b0011;
         3'd6: pattern = 4'b0001;
         3'd7: pattern = 4'b1001;
         default: pattern = 4'b0000;
      endcase
   end

   assign busy_o    = busy;
   assign done_o    = (state == S_DONE);
   assign aborted_o = (state == S_DONE) && aborted_q;
   assign leg_cnt_o = leg_cnt;
   assign signal_o  = (coil_en && ((HOLD_EN != 0) || (state != S_IDLE))) ? pattern : 4'b0000;

endmodule
